cache_req_arbiter: RTL and testbench
====================================

CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of native masters sharing one cache front-end port (legal range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; NBYTES = DATA_W/8.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port m_valid, input, N_MASTERS, per-master request.
REQ-007 SHALL have port m_addr, input, N_MASTERS*ADDR_W, packed; master i at [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port m_wdata, input, N_MASTERS*DATA_W, packed per master.
REQ-009 SHALL have port m_wstrb, input, N_MASTERS*NBYTES, packed per master; all-zero means read.
REQ-010 SHALL have port m_rdata, output, N_MASTERS*DATA_W, per-master read data.
REQ-011 SHALL have port m_ready, output, N_MASTERS, one-cycle completion pulse per master.
REQ-012 SHALL have ports s_valid (output, 1), s_addr (output, ADDR_W), s_wdata (output, DATA_W), s_wstrb (output, NBYTES), s_rdata (input, DATA_W), s_ready (input, 1), the cache front-end port.
REQ-013 SHALL have port grant_id, output, $clog2(N_MASTERS), index of the master owning the current transaction.

Function
REQ-014 SHALL implement FSM with states IDLE and BUSY.
REQ-015 In IDLE with any m_valid high, SHALL select one master round-robin and, at the next edge, enter BUSY, load grant_id and register that master's addr/wdata/wstrb.
REQ-016 Round-robin search SHALL start at (last_grant+1) mod N_MASTERS and wrap; last_grant SHALL update only on completion.
REQ-017 In IDLE with no m_valid, SHALL stay in IDLE with s_valid=0.
REQ-018 In BUSY, s_valid SHALL be 1 and s_addr/s_wdata/s_wstrb SHALL come only from the registered request, never from live master inputs.
REQ-019 In BUSY with s_ready=1, SHALL assert m_ready[grant_id] in that same cycle, drive m_rdata for grant_id = s_rdata, set last_grant=grant_id and return to IDLE at the next edge.
REQ-020 m_ready SHALL be one-hot or zero; m_rdata of non-granted masters and all m_rdata outside the s_ready cycle SHALL be 0.
REQ-021 Added latency SHALL be exactly one cycle, from m_valid sampled in IDLE to s_valid; m_valid to m_ready minimum = 2 cycles when the cache answers in 1.
REQ-022 Masters SHALL hold m_valid until m_ready; a master dropping m_valid while granted SHALL NOT abort the transaction (it completes from registered copy).
REQ-023 A master whose m_valid is still high on its m_ready cycle SHALL NOT be re-granted from that stale cycle; arbitration SHALL resume only in the following IDLE cycle.
REQ-024 Simultaneous requests from all masters SHALL be served in strict rotation; no master SHALL wait more than N_MASTERS-1 transactions.
REQ-025 s_ready seen in IDLE SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, s_valid=0, s_addr/s_wdata/s_wstrb=0, m_ready=0, m_rdata=0, grant_id=0, last_grant=N_MASTERS-1 (master 0 first priority).
REQ-027 Reset during BUSY SHALL drop the in-flight request without an m_ready pulse.

Structure
REQ-028 State encoding (IDLE=0, BUSY=1) SHALL live in the shared cache header/package alongside existing cache macros.
REQ-029 Round-robin selection SHALL be one combinational sub-module cache_rr_pick (inputs req vector, last_grant; outputs found, index).

Verification
REQ-030 Single read: m_valid[1]=1, addr=0x100, wstrb=0; cache returns 0xDEADBEEF with s_ready one cycle after s_valid -> s_valid at cycle 1, m_ready[1] and m_rdata[1]=0xDEADBEEF at cycle 2, grant_id=1.
REQ-031 Contention: m_valid=2'b11 held, N_MASTERS=2 after reset -> grants in order 0,1,0,1; m_ready never two-hot.
REQ-032 Write: master 0 addr=0x40, wdata=0x12345678, wstrb=4'b0011, then drops m_valid after grant -> s_wstrb=0011, s_wdata=0x12345678 held until s_ready, m_ready[0] pulses once.
REQ-033 Stalled cache: s_ready delayed 5 cycles -> s_valid and s_addr stable all 5 cycles; other master's request waits and is granted next.
REQ-034 Reset asserted mid-BUSY -> outputs return to reset values asynchronously, no m_ready pulse; first post-reset grant goes to master 0.

Source files
------------

// File: rtl/cache_req_arbiter_pkg.sv
// Shared cache package: arbiter FSM state encoding and round-robin helper.
//
// Contents:
//   arb_state_e - arbiter FSM states (IDLE=0, BUSY=1)
//   rr_next     - candidate index at a given offset past the last grant
package cache_req_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Master index 'off' positions after 'last', wrapping over n masters.
   function automatic int rr_next(input int last, input int off, input int n);
      return (last + off) % n;
   endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational round-robin picker.
//
// Ports:
//   req        - per-master request vector
//   last_grant - master that most recently completed a transaction
//   found      - at least one request is pending
//   index      - first requester at or after last_grant+1, wrapping
module cache_rr_pick
   import cache_req_arbiter_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int IDX_W     = $clog2(N_MASTERS)
) (
   input  logic [N_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]     last_grant,
   output logic                 found,
   output logic [IDX_W-1:0]     index
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down to the nearest so the nearest
   // pending requester after last_grant is the one left standing.
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      for (int off = N_MASTERS; off >= 1; off--) begin
         cand = IDX_W'(rr_next(int'(last_grant), off, N_MASTERS));
         if (req[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache front-end port among N_MASTERS
// native masters. A granted request is captured into local registers so
// the cache side never sees live master inputs while a transaction is
// outstanding.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   m_valid/m_addr/
//   m_wdata/m_wstrb       - packed per-master requests (wstrb==0 -> read)
//   m_rdata, m_ready      - per-master read data and completion pulse
//   s_valid/s_addr/
//   s_wdata/s_wstrb       - request toward the cache
//   s_rdata, s_ready      - cache response
//   grant_id              - master owning the current transaction
module cache_req_arbiter
   import cache_req_arbiter_pkg::*;
#(
   parameter  int N_MASTERS = 2,
   parameter  int ADDR_W    = 32,
   parameter  int DATA_W    = 32,
   localparam int NBYTES    = DATA_W / 8,
   localparam int IDX_W     = $clog2(N_MASTERS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_MASTERS-1:0]          m_valid,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   input  logic [N_MASTERS*NBYTES-1:0]   m_wstrb,
   output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
   output logic [N_MASTERS-1:0]          m_ready,
   output logic                          s_valid,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   output logic [NBYTES-1:0]             s_wstrb,
   input  logic [DATA_W-1:0]             s_rdata,
   input  logic                          s_ready,
   output logic [IDX_W-1:0]              grant_id
);

   arb_state_e        state_q;
   logic [IDX_W-1:0]  grant_q;
   logic [IDX_W-1:0]  last_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NBYTES-1:0] wstrb_q;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic              done;

   cache_rr_pick #(
      .N_MASTERS (N_MASTERS)
   ) u_pick (
      .req        (m_valid),
      .last_grant (last_q),
      .found      (pick_found),
      .index      (pick_idx)
   );

   // s_ready only means something while a request is outstanding.
   assign done = (state_q == BUSY) && s_ready;

   // Arbitration happens only in IDLE, so a master still holding m_valid
   // on its completion cycle is never re-granted from that stale cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(N_MASTERS - 1);
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q <= BUSY;
                  grant_q <= pick_idx;
                  addr_q  <= m_addr [pick_idx*ADDR_W +: ADDR_W];
                  wdata_q <= m_wdata[pick_idx*DATA_W +: DATA_W];
                  wstrb_q <= m_wstrb[pick_idx*NBYTES +: NBYTES];
               end
            end
            BUSY: begin
               if (s_ready) begin
                  state_q <= IDLE;
                  last_q  <= grant_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_valid  = (state_q == BUSY);
   assign s_addr   = addr_q;
   assign s_wdata  = wdata_q;
   assign s_wstrb  = wstrb_q;
   assign grant_id = grant_q;

   // Completion is routed combinationally so the master sees it in the
   // same cycle the cache answers; everything else reads as zero.
   always_comb begin
      m_ready = '0;
      m_rdata = '0;
      if (done) begin
         m_ready[grant_q]                  = 1'b1;
         m_rdata[grant_q*DATA_W +: DATA_W] = s_rdata;
      end
   end

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NB = DW / 8;

   logic            clk;
   logic            reset;
   logic [N-1:0]    m_valid;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_wdata;
   logic [N*NB-1:0] m_wstrb;
   logic [N*DW-1:0] m_rdata;
   logic [N-1:0]    m_ready;
   logic            s_valid;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_wdata;
   logic [NB-1:0]   s_wstrb;
   logic [DW-1:0]   s_rdata;
   logic            s_ready;
   logic            grant_id;

   logic            cache_rdy;
   logic            spurious_rdy;
   int              cache_lat;
   int              cnt;

   int              n_cmp;
   int              n_bad;
   int              done_cnt;

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];

   cache_req_arbiter #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .m_valid  (m_valid),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_wstrb  (m_wstrb),
      .m_rdata  (m_rdata),
      .m_ready  (m_ready),
      .s_valid  (s_valid),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_wstrb  (s_wstrb),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready),
      .grant_id (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign s_ready = cache_rdy | spurious_rdy;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cache data model: a fixed word at 0x100, otherwise address/inverse.
   function automatic logic [31:0] cache_word(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Cache responder: answers after s_valid has been seen cache_lat cycles.
   initial begin
      cache_rdy = 1'b0;
      s_rdata   = '0;
      cnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset || cache_rdy) begin
            cache_rdy = 1'b0;
            s_rdata   = '0;
            cnt       = 0;
         end else if (s_valid) begin
            cnt++;
            if (cnt > cache_lat) begin
               cache_rdy = 1'b1;
               s_rdata   = cache_word(s_addr);
            end
         end
      end
   end

   // Monitor: every completion pops the next expected transaction.
   initial begin
      exp_t        e;
      logic [63:0] exp_rd;
      logic [1:0]  exp_rdy;
      done_cnt = 0;
      forever begin
         @(negedge clk);
         if (m_ready !== '0) begin
            chk("m_ready_onehot", 64'($countones(m_ready)), 64'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_m_ready", 64'(m_ready), 64'd0);
            end else begin
               e       = exp_q.pop_front();
               exp_rd  = '0;
               exp_rd[e.id*32 +: 32] = e.rdata;
               exp_rdy = '0;
               exp_rdy[e.id] = 1'b1;
               chk("m_ready", 64'(m_ready), 64'(exp_rdy));
               chk("m_rdata", m_rdata, exp_rd);
               chk("grant_id", 64'(grant_id), 64'(e.id));
               chk("s_addr", 64'(s_addr), 64'(e.addr));
               chk("s_wdata", 64'(s_wdata), 64'(e.wdata));
               chk("s_wstrb", 64'(s_wstrb), 64'(e.wstrb));
            end
            done_cnt++;
         end else begin
            chk("m_rdata_idle_zero", m_rdata, 64'd0);
         end
      end
   end

   task automatic push(input int id, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] rd);
      exp_t e;
      e.id = id; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
      exp_q.push_back(e);
   endtask

   task automatic drive(input int id, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws);
      m_addr [id*AW +: AW] = a;
      m_wdata[id*DW +: DW] = wd;
      m_wstrb[id*NB +: NB] = ws;
      m_valid[id]          = 1'b1;
   endtask

   // Returns at posedge+1 of the edge that follows the target completion.
   task automatic wait_done(input int target, input string nm);
      int budget;
      budget = 100;
      do begin
         @(posedge clk);
         budget--;
      end while (done_cnt < target && budget > 0);
      #1;
      if (done_cnt < target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: completions %0d required %0d", nm, done_cnt, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      reset        = 1'b1;
      m_valid      = '0;
      m_addr       = '0;
      m_wdata      = '0;
      m_wstrb      = '0;
      spurious_rdy = 1'b0;
      cache_lat    = 1;

      // Reset values
      #2;
      chk("rst_s_valid", 64'(s_valid), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_m_ready", 64'(m_ready), 64'd0);
      chk("rst_m_rdata", m_rdata, 64'd0);
      chk("rst_s_addr", 64'(s_addr), 64'd0);
      chk("rst_s_wdata", 64'(s_wdata), 64'd0);
      chk("rst_s_wstrb", 64'(s_wstrb), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;

      // Single read from master 1
      @(posedge clk); #1;
      drive(1, 32'h100, 32'h0, 4'h0);
      push(1, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
      @(negedge clk);
      chk("rd_c0_s_valid", 64'(s_valid), 64'd0);
      @(negedge clk);
      chk("rd_c1_s_valid", 64'(s_valid), 64'd1);
      chk("rd_c1_grant", 64'(grant_id), 64'd1);
      chk("rd_c1_m_ready", 64'(m_ready), 64'd0);
      @(negedge clk);
      chk("rd_c2_m_ready", 64'(m_ready), 64'b10);
      chk("rd_c2_m_rdata", m_rdata, {32'hDEADBEEF, 32'h0});
      wait_done(1, "rd");
      m_valid[1] = 1'b0;

      // Contention: both held, strict alternation from master 0
      @(posedge clk); #1;
      drive(0, 32'h200, 32'h0, 4'h0);
      drive(1, 32'h300, 32'h0, 4'h0);
      push(0, 32'h200, 32'h0, 4'h0, 32'h0200FDFF);
      push(1, 32'h300, 32'h0, 4'h0, 32'h0300FCFF);
      push(0, 32'h200, 32'h0, 4'h0, 32'h0200FDFF);
      push(1, 32'h300, 32'h0, 4'h0, 32'h0300FCFF);
      wait_done(5, "contend");
      m_valid = '0;

      // Write from master 0 which drops m_valid once granted
      cache_lat = 3;
      @(posedge clk); #1;
      drive(0, 32'h40, 32'h12345678, 4'b0011);
      push(0, 32'h40, 32'h12345678, 4'b0011, 32'h0040FFBF);
      @(posedge clk); #1;
      m_valid[0]      = 1'b0;
      m_addr[31:0]    = 32'hFFFFFFFF;
      m_wdata[31:0]   = 32'h0;
      m_wstrb[3:0]    = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wr_hold_s_valid", 64'(s_valid), 64'd1);
         chk("wr_hold_s_wdata", 64'(s_wdata), 64'h12345678);
         chk("wr_hold_s_wstrb", 64'(s_wstrb), 64'b0011);
      end
      wait_done(6, "wr");
      m_addr  = '0;
      m_wstrb = '0;

      // Stalled cache: master 1 in flight, master 0 waits then wins
      cache_lat = 5;
      @(posedge clk); #1;
      drive(1, 32'h500, 32'h0, 4'h0);
      push(1, 32'h500, 32'h0, 4'h0, 32'h0500FAFF);
      @(posedge clk); #1;
      drive(0, 32'h600, 32'h0, 4'h0);
      push(0, 32'h600, 32'h0, 4'h0, 32'h0600F9FF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_s_valid", 64'(s_valid), 64'd1);
         chk("stall_s_addr", 64'(s_addr), 64'h500);
         chk("stall_grant", 64'(grant_id), 64'd1);
         chk("stall_m_ready", 64'(m_ready), 64'd0);
      end
      wait_done(7, "stall_m1");
      m_valid[1] = 1'b0;
      wait_done(8, "stall_m0");
      m_valid[0] = 1'b0;

      // s_ready while idle is ignored
      @(posedge clk); #1;
      spurious_rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("idle_rdy_m_ready", 64'(m_ready), 64'd0);
         chk("idle_rdy_s_valid", 64'(s_valid), 64'd0);
      end
      @(posedge clk); #1;
      spurious_rdy = 1'b0;

      // Reset in the middle of a stalled transaction
      cache_lat = 10;
      @(posedge clk); #1;
      drive(1, 32'h700, 32'h0, 4'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_busy_s_valid", 64'(s_valid), 64'd1);
      chk("mid_busy_grant", 64'(grant_id), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_s_valid", 64'(s_valid), 64'd0);
      chk("async_rst_grant", 64'(grant_id), 64'd0);
      chk("async_rst_m_ready", 64'(m_ready), 64'd0);
      chk("async_rst_s_addr", 64'(s_addr), 64'd0);
      chk("async_rst_s_wstrb", 64'(s_wstrb), 64'd0);
      m_valid   = '0;
      cache_lat = 1;
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;

      // First post-reset grant goes to master 0
      @(posedge clk); #1;
      drive(0, 32'h800, 32'h0, 4'h0);
      drive(1, 32'h900, 32'h0, 4'h0);
      push(0, 32'h800, 32'h0, 4'h0, 32'h0800F7FF);
      push(1, 32'h900, 32'h0, 4'h0, 32'h0900F6FF);
      @(negedge clk);
      chk("post_rst_c0_s_valid", 64'(s_valid), 64'd0);
      @(negedge clk);
      chk("post_rst_c1_s_valid", 64'(s_valid), 64'd1);
      chk("post_rst_c1_grant", 64'(grant_id), 64'd0);
      wait_done(9, "post_rst_m0");
      m_valid[0] = 1'b0;
      wait_done(10, "post_rst_m1");
      m_valid[1] = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("leftover_expected", 64'(exp_q.size()), 64'd0);
      chk("total_completions", 64'(done_cnt), 64'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
